// File: rtl/fsm_share_pkg.sv
// Shared types and helpers for the time-shared FSM scheduler.
package fsm_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int OWNER_W = 3;
  localparam int CNT_W   = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_pick
  import fsm_share_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  first;
  logic [IW:0]    sum;

  // Rotate so the pointer position lands at bit 0, then find the lowest set bit.
  always_comb begin
    dbl   = {req_i, req_i} >> ptr_i;
    rot   = dbl[N-1:0];
    first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) first = IW'(i);
    end
    sum = {1'b0, ptr_i} + {1'b0, first};
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    idx_o    = sum[IW-1:0];
    onehot_o = N'(1) << idx_o;
    valid_o  = |req_i;
  end

endmodule

// File: rtl/fsm_share_sched.sv
// Round-robin arbiter and sequencer that time-shares one two-input/two-output FSM
// between N_REQ requesters: clear, stream BURST_LEN a/b bits, capture y0/y1, report done.
module fsm_share_sched
  import fsm_share_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   a_in,
  input  logic [N_REQ-1:0]   b_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               abort,
  output logic [OWNER_W-1:0] owner,
  output logic               fsm_clr,
  output logic               fsm_a,
  output logic               fsm_b,
  input  logic               fsm_y0,
  input  logic               fsm_y1,
  output logic               y0_cap,
  output logic               y1_cap,
  output logic [1:0]         state_dbg
);

  localparam int IW = clog2(N_REQ);

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   done_q;
  logic               abort_q;
  logic               clr_q;
  logic               y0_q;
  logic               y1_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      own_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [N_REQ-1:0]   pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic [IW-1:0]      ptr_d;
  logic               owner_req;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .valid_o  (pick_vld)
  );

  always_comb begin
    ptr_d     = (own_q == IW'(N_REQ - 1)) ? '0 : own_q + 1'b1;
    owner_req = req[own_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      abort_q <= 1'b0;
      clr_q   <= 1'b0;
      y0_q    <= 1'b0;
      y1_q    <= 1'b0;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
    end else begin
      done_q  <= '0;
      abort_q <= 1'b0;
      clr_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            own_q   <= pick_idx;
            gnt_q   <= pick_oh;
            clr_q   <= 1'b1;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          cnt_q   <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          // Losing the owner's request wins over burst completion on the same edge.
          if (!owner_req) begin
            abort_q <= 1'b1;
            gnt_q   <= '0;
            ptr_q   <= ptr_d;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
              done_q  <= gnt_q;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          y0_q    <= fsm_y0;
          y1_q    <= fsm_y1;
          ptr_q   <= ptr_d;
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign abort     = abort_q;
  assign owner     = OWNER_W'(own_q);
  assign fsm_clr   = clr_q;
  assign fsm_a     = (state_q == ST_RUN) & a_in[own_q];
  assign fsm_b     = (state_q == ST_RUN) & b_in[own_q];
  assign y0_cap    = y0_q;
  assign y1_cap    = y1_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fsm_share_sched.sv
// Directed-plus-random bench for fsm_share_sched with a small stand-in shared FSM.
module tb_fsm_share_sched;
  import fsm_share_pkg::*;

  localparam int N  = 4;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] a_in = '0;
  logic [N-1:0] b_in = '0;
  logic [N-1:0] gnt, done;
  logic         abort, fsm_clr, fsm_a, fsm_b, fsm_y0, fsm_y1, y0_cap, y1_cap;
  logic [2:0]   owner;
  logic [1:0]   state_dbg;

  int total = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int cyc = 0;
  int ptr_m = 0;
  bit y0_m = 1'b0;
  bit y1_m = 1'b0;
  int last_gnt_cyc = -1;

  fsm_share_sched #(.N_REQ(N), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .done      (done),
    .abort     (abort),
    .owner     (owner),
    .fsm_clr   (fsm_clr),
    .fsm_a     (fsm_a),
    .fsm_b     (fsm_b),
    .fsm_y0    (fsm_y0),
    .fsm_y1    (fsm_y1),
    .y0_cap    (y0_cap),
    .y1_cap    (y1_cap),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // stand-in shared FSM: y0 = odd count of a=1 cycles, y1 = at least two a&b cycles since clear
  logic [2:0] na, nab;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      na  <= '0;
      nab <= '0;
    end else if (fsm_clr) begin
      na  <= '0;
      nab <= '0;
    end else begin
      na  <= na + {2'b0, fsm_a};
      nab <= nab + {2'b0, fsm_a & fsm_b};
    end
  end
  assign fsm_y0 = na[0];
  assign fsm_y1 = (nab >= 3'd2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // invariants, sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      check("inv_gnt_onehot0", 32'($onehot0(gnt)), 1);
      check("inv_done_in_gnt", 32'(done & ~gnt), 0);
      if (state_dbg != ST_RUN) check("inv_ab_outside_run", {fsm_a, fsm_b}, 0);
    end
  end

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int off = 0; off < N; off++) begin
      if (r[(p + off) % N]) return (p + off) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one full grant from the IDLE cycle before the grant edge to the IDLE cycle after it
  task automatic do_burst(input bit ones, input int drop_at, input logic [N-1:0] add_in_done,
                          input bit release_req, input bit chk_space);
    int own;
    int cnt_a;
    int cnt_ab;
    cnt_a  = 0;
    cnt_ab = 0;
    own = pick(req, ptr_m);
    check("burst_has_req", 32'(own >= 0), 1);
    if (own < 0) return;
    tick();
    check("grant_gnt", gnt, 32'(1 << own));
    check("grant_owner", owner, own);
    check("grant_clr", fsm_clr, 1);
    check("grant_ab_zero", {fsm_a, fsm_b}, 0);
    check("grant_abort_low", abort, 0);
    check("grant_done_low", done, 0);
    if (chk_space) check("grant_spacing", cyc - last_gnt_cyc, BL + 3);
    last_gnt_cyc = cyc;
    for (int i = 0; i < BL; i++) begin
      tick();
      a_in = ones ? '1 : 4'($urandom);
      b_in = ones ? '1 : 4'($urandom);
      if (i == drop_at) req[own] = 1'b0;
      #1;
      check("run_clr_low", fsm_clr, 0);
      check("run_fsm_a", fsm_a, a_in[own]);
      check("run_fsm_b", fsm_b, b_in[own]);
      check("run_gnt", gnt, 32'(1 << own));
      cnt_a  += int'(a_in[own]);
      cnt_ab += int'(a_in[own] & b_in[own]);
      if (i == drop_at) begin
        tick();
        check("abort_pulse", abort, 1);
        check("abort_gnt", gnt, 0);
        check("abort_no_done", done, 0);
        check("abort_y0_kept", y0_cap, y0_m);
        check("abort_y1_kept", y1_cap, y1_m);
        ptr_m = (own + 1) % N;
        return;
      end
    end
    tick();
    check("done_pulse", done, 32'(1 << own));
    check("done_gnt_held", gnt, 32'(1 << own));
    check("done_ab_zero", {fsm_a, fsm_b}, 0);
    req = req | add_in_done;
    #1;
    check("done_gnt_single", gnt, 32'(1 << own));
    y0_m = (cnt_a % 2) == 1;
    y1_m = cnt_ab >= 2;
    tick();
    check("post_done_low", done, 0);
    check("post_gnt_low", gnt, 0);
    check("cap_y0", y0_cap, y0_m);
    check("cap_y1", y1_cap, y1_m);
    ptr_m = (own + 1) % N;
    if (release_req) req[own] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int drop;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_abort", abort, 0);
    check("rst_owner", owner, 0);
    check("rst_clr", fsm_clr, 0);
    check("rst_ab", {fsm_a, fsm_b}, 0);
    check("rst_caps", {y0_cap, y1_cap}, 0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b1;
    tick();
    check("idle_quiet_gnt", gnt, 0);
    check("idle_quiet_clr", fsm_clr, 0);

    // single requester, a=b=1 for the whole burst
    req = 4'b0001;
    do_burst(1'b1, -1, '0, 1'b1, 1'b0);
    check("ones_y0", y0_cap, 0);
    check("ones_y1", y1_cap, 1);

    // asynchronous reset in the middle of RUN
    req = 4'b0001;
    tick();
    tick();
    a_in = '1;
    b_in = '1;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_gnt", gnt, 0);
    check("midrst_done", done, 0);
    check("midrst_abort", abort, 0);
    check("midrst_owner", owner, 0);
    check("midrst_clr", fsm_clr, 0);
    check("midrst_ab", {fsm_a, fsm_b}, 0);
    check("midrst_caps", {y0_cap, y1_cap}, 0);
    req = '0;
    tick();
    reset = 1'b1;
    ptr_m = 0;
    y0_m = 1'b0;
    y1_m = 1'b0;
    last_gnt_cyc = -1;
    repeat (3) begin
      tick();
      check("postrst_no_done", done, 0);
      check("postrst_idle", state_dbg, ST_IDLE);
    end

    // all requesters held: strict rotation, fixed spacing
    req = '1;
    for (int k = 0; k < 5; k++) begin
      do_burst(1'b0, -1, '0, 1'b0, k > 0);
      check("rot_owner", owner, k % N);
    end

    // pointer at 2 with only 0 and 1 requesting wraps to 0 first
    req = 4'b0010;
    do_burst(1'b0, -1, '0, 1'b1, 1'b0);
    req = 4'b0011;
    do_burst(1'b0, -1, '0, 1'b1, 1'b0);
    check("wrap_owner0", owner, 0);
    do_burst(1'b0, -1, '0, 1'b1, 1'b0);
    check("wrap_owner1", owner, 1);

    // owner 2 drops its request in the second RUN cycle
    req = '1;
    do_burst(1'b0, 1, '0, 1'b0, 1'b0);
    check("drop_owner", owner, 2);
    req = '1;
    do_burst(1'b0, -1, '0, 1'b1, 1'b0);
    check("after_abort_owner", owner, 3);

    // request appearing during DONE waits for IDLE
    req = 4'b0001;
    do_burst(1'b0, -1, 4'b1000, 1'b1, 1'b0);
    check("late_req_not_yet", gnt, 0);
    do_burst(1'b0, -1, '0, 1'b1, 1'b0);
    check("late_req_owner", owner, 3);

    // random traffic
    for (int k = 0; k < 20; k++) begin
      if (req == '0) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          check("rand_idle_gnt", gnt, 0);
        end
      end
      req = req | 4'($urandom_range(1, 15));
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BL - 1)) : -1;
      do_burst(1'b0, drop, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
